// File: rtl/result_frame_pkg.sv
// result_frame_pkg
//   Shared types and defaults for the result frame collector.
//   - state_t   : collector state machine encoding (IDLE, COLLECT, DRAIN)
//   - DW_DEF    : default result word width
//   - DEPTH_DEF : default frame buffer depth (power of 2, >= 2)
package result_frame_pkg;

    localparam int DW_DEF    = 9;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/gated_clk_cell.sv
// gated_clk_cell
//   Latch-based integrated clock gate. The enable is captured by a latch that
//   is transparent while clk is low, so it cannot change while clk is high and
//   the gated clock never glitches.
//   Only compiled when RESULT_FRAME_CLK_GATE_EN is defined.
//   Ports:
//     clk  - free-running input clock
//     en   - gate enable (1 = pass clock)
//     gclk - gated output clock
`ifdef RESULT_FRAME_CLK_GATE_EN
module gated_clk_cell (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    always_latch begin
        if (!clk) en_lat <= en;
    end

    assign gclk = clk & en_lat;

endmodule
`endif

// File: rtl/result_frame_collector.sv
// result_frame_collector
//   Captures a variable-length result burst (contiguous in_valid cycles) into a
//   local buffer, then replays it as a framed valid/ready stream with a last
//   marker. Words beyond DEPTH, words arriving while a frame drains, and words
//   arriving on the cycle the drain completes are dropped and flag ovf_err.
//
//   Build option: RESULT_FRAME_CLK_GATE_EN
//     defined   - buffer bank clocked through gated_clk_cell, enabled only on
//                 write cycles when cg_en=1
//     undefined - buffer bank on clk with a write-enable; cg_en unused
//   Port behaviour is cycle-identical in both builds.
//
//   Ports:
//     clk, rst_n          - clock, asynchronous active-low reset
//     cg_en               - clock-gating allowed
//     in_valid, in_data   - upstream result burst
//     busy                - frame draining; upstream must hold off
//     out_valid, out_data - frame word (data forced to 0 when not valid)
//     out_last            - final word of frame
//     out_ready           - consumer accept
//     frame_len           - stored word count during drain, else 0
//     ovf_err             - sticky per-frame drop flag
module result_frame_collector
    import result_frame_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cg_en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [CW-1:0] frame_len,
    output logic          ovf_err
);

    localparam int AW = $clog2(DEPTH);

    state_t        state, state_nxt;
    logic [CW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] len_q, len_nxt;
    logic          ovf_q, ovf_nxt;

    logic [DW-1:0] mem [DEPTH];

    logic          hs;
    logic          at_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          room;

    // ------------------------------------------------------------------
    // Output decode (all from registered state / buffer)
    // ------------------------------------------------------------------
    assign out_valid = (state == DRAIN);
    assign busy      = out_valid;
    assign at_last   = ({1'b0, rd_ptr} == (len_q - CW'(1)));
    assign out_last  = out_valid & at_last;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign hs        = out_valid & out_ready;
    assign frame_len = len_q;
    assign ovf_err   = ovf_q;

    // ------------------------------------------------------------------
    // Buffer write port. The first word of a burst lands in slot 0 while
    // still in IDLE, so the address comes from the state, not wr_ptr.
    // ------------------------------------------------------------------
    assign room    = (wr_ptr < CW'(DEPTH));
    assign wr_addr = (state == IDLE) ? '0 : wr_ptr[AW-1:0];
    assign wr_en   = in_valid & ((state == IDLE) | ((state == COLLECT) & room));

    // ------------------------------------------------------------------
    // State machine: register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            len_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            len_q  <= len_nxt;
            ovf_q  <= ovf_nxt;
        end
    end

    // ------------------------------------------------------------------
    // State machine: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        len_nxt    = len_q;
        ovf_nxt    = ovf_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt  = COLLECT;
                    wr_ptr_nxt = CW'(1);
                    ovf_nxt    = 1'b0;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    // wr_ptr stops at DEPTH, which also saturates frame_len
                    if (room) wr_ptr_nxt = wr_ptr + CW'(1);
                    else      ovf_nxt    = 1'b1;
                end else begin
                    state_nxt  = DRAIN;
                    len_nxt    = wr_ptr;
                    rd_ptr_nxt = '0;
                end
            end
            DRAIN: begin
                // Upstream is not allowed to talk during a drain, including
                // the cycle the final handshake completes.
                if (in_valid) ovf_nxt = 1'b1;
                if (hs) begin
                    if (at_last) begin
                        state_nxt  = IDLE;
                        len_nxt    = '0;
                        rd_ptr_nxt = '0;
                        wr_ptr_nxt = '0;
                    end else begin
                        rd_ptr_nxt = rd_ptr + AW'(1);
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                wr_ptr_nxt = '0;
                rd_ptr_nxt = '0;
                len_nxt    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer bank (never cleared; only pointers reset)
    // ------------------------------------------------------------------
`ifdef RESULT_FRAME_CLK_GATE_EN
    logic bank_en;
    logic bank_clk;

    // With gating allowed, the bank only sees edges when upstream may write.
    assign bank_en = !cg_en | (in_valid & (state != DRAIN));

    gated_clk_cell u_bank_icg (
        .clk  (clk),
        .en   (bank_en),
        .gclk (bank_clk)
    );

    always_ff @(posedge bank_clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
    end
`else
    logic unused_cg_en;
    assign unused_cg_en = cg_en;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= in_data;
    end
`endif

endmodule

// File: tb/tb_result_frame_collector.sv
module tb_result_frame_collector;
    import result_frame_pkg::*;

    localparam int DW    = DW_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cg_en = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          busy, out_valid, out_last, ovf_err;
    logic [DW-1:0] out_data;
    logic [CW-1:0] frame_len;

    result_frame_collector #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_len (frame_len),
        .ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a frame is a queue being collected, then a queue
    // being replayed word by word.
    // ------------------------------------------------------------------
    bit            m_coll, m_drain, m_ovf;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_fr[$];
    int            m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_coll = 0; m_drain = 0; m_ovf = 0; m_idx = 0;
            m_q.delete(); m_fr.delete();
        end else if (m_drain) begin
            if (in_valid) m_ovf = 1;
            if (out_ready) begin
                if (m_idx == m_fr.size() - 1) begin
                    m_drain = 0;
                    m_fr.delete();
                    m_idx = 0;
                end else m_idx++;
            end
        end else if (m_coll) begin
            if (in_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(in_data);
                else m_ovf = 1;
            end else begin
                m_fr = m_q;
                m_q.delete();
                m_idx = 0;
                m_coll = 0;
                m_drain = 1;
            end
        end else if (in_valid) begin
            m_q.delete();
            m_q.push_back(in_data);
            m_coll = 1;
            m_ovf = 0;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    logic [DW-1:0] e_data;
    logic          e_last;
    logic [CW-1:0] e_len;
    always @(negedge clk) begin
        e_data = m_drain ? m_fr[m_idx] : '0;
        e_last = m_drain && (m_idx == m_fr.size() - 1);
        e_len  = m_drain ? CW'(m_fr.size()) : '0;
        chk("busy",      busy,      m_drain);
        chk("out_valid", out_valid, m_drain);
        chk("out_data",  out_data,  e_data);
        chk("out_last",  out_last,  e_last);
        chk("frame_len", frame_len, e_len);
        chk("ovf_err",   ovf_err,   m_ovf);
    end

    // Handshake log for literal expectations.
    logic [DW-1:0] hs_log[$];
    bit            last_log[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            hs_log.push_back(out_data);
            last_log.push_back(out_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [DW-1:0] w[$]);
        foreach (w[i]) begin
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic drain(input bit pat[$], input int budget);
        int n = 0;
        while (busy) begin
            out_ready = (pat.size() != 0) ? pat.pop_front() : 1'b1;
            tick();
            n++;
            if (n > budget) begin
                chk("drain_timeout", 1, 0);
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic drain_rand(input int budget);
        int n = 0;
        while (busy && n <= budget) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b1;
                in_data  = DW'($urandom);
            end else in_valid = 1'b0;
            tick();
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (busy) chk("drain_rand_timeout", 1, 0);
    endtask

    task automatic chk_log(input string name, input logic [DW-1:0] exp[$]);
        chk({name, "_count"}, hs_log.size(), exp.size());
        foreach (exp[i]) begin
            if (i < hs_log.size()) chk({name, "_word"}, hs_log[i], exp[i]);
        end
    endtask

    initial begin
        logic [DW-1:0] w[$];
        bit            p[$];

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_ovf", ovf_err, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Five-word burst, always ready
        hs_log.delete(); last_log.delete();
        w = '{9'd3, 9'd17, 9'd255, 9'd0, 9'd511};
        burst(w);
        chk("b5_idle_after_last_word", busy, 0);
        tick();
        chk("b5_first_valid", out_valid, 1);
        chk("b5_len", frame_len, 5);
        p.delete();
        drain(p, 20);
        chk_log("b5", w);
        if (last_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("b5_last_flag", last_log[i], (i == 4));
        end
        tick();

        // Backpressure 0,1,0,0,1
        hs_log.delete();
        w = '{9'd100, 9'd200};
        burst(w);
        tick();
        p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        drain(p, 20);
        chk_log("bp", w);
        chk("bp_data_zero_after", out_data, 0);
        chk("bp_valid_after", out_valid, 0);
        tick();

        // Overflow: 11 words, only 1..8 kept
        hs_log.delete();
        w.delete();
        for (int i = 1; i <= 11; i++) w.push_back(DW'(i));
        burst(w);
        tick();
        chk("ovf_len_sat", frame_len, 8);
        chk("ovf_flag", ovf_err, 1);
        p.delete();
        drain(p, 20);
        w = '{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8};
        chk_log("ovf", w);
        chk("ovf_sticky_idle", ovf_err, 1);
        tick();
        in_valid = 1'b1; in_data = 9'd42;
        tick();
        in_valid = 1'b0;
        chk("ovf_clear_on_burst", ovf_err, 0);
        tick();
        chk("b42_len", frame_len, 1);
        drain(p, 10);
        tick();

        // Single word 7, then a word on the completing handshake (dropped),
        // then a burst the very next cycle (accepted).
        hs_log.delete();
        w = '{9'd7};
        burst(w);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_last", out_last, 1);
        chk("single_len", frame_len, 1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 9'd99;
        tick();
        out_ready = 1'b0;
        chk("edge_drop_idle", busy, 0);
        chk("edge_drop_ovf", ovf_err, 1);
        in_data = 9'd6;
        tick();
        in_valid = 1'b0;
        chk("next_burst_ovf_clear", ovf_err, 0);
        tick();
        drain(p, 10);
        w = '{9'd7, 9'd6};
        chk_log("edge", w);
        tick();

        // in_valid during DRAIN: dropped, drain unaffected
        hs_log.delete();
        w = '{9'd9, 9'd8, 9'd7};
        burst(w);
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 9'd77;
        tick();
        in_valid = 1'b0;
        chk("viol_ovf", ovf_err, 1);
        chk("viol_busy", busy, 1);
        chk("viol_data_held", out_data, 9);
        drain(p, 20);
        chk_log("viol", w);
        tick();

        // Reset mid-drain: outputs drop immediately
        w = '{9'd1, 9'd2, 9'd3, 9'd4};
        burst(w);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_len", frame_len, 0);
        chk("arst_ovf", ovf_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_after", busy, 0);

        // Randomised bursts, random backpressure, cg_en and violations
        for (int it = 0; it < 60; it++) begin
            int len;
            cg_en = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            w.delete();
            for (int k = 0; k < len; k++) w.push_back(DW'($urandom));
            burst(w);
            tick();
            drain_rand(200);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
